// File: rtl/result_accumulator.sv
// Frame accumulator: saturating sum and signed max/min over N_SAMPLES result triples.
// Summary appears the cycle after the final transfer and is held until out_ready.
module result_accumulator #(
    parameter int N_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ans1,
    input  logic [3:0] ans2,
    input  logic [3:0] ans3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sum,
    output logic [3:0] max_val,
    output logic [3:0] min_val,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [3:0]        LAST = 4'(N_SAMPLES - 1);
    localparam logic signed [9:0] SMAX = 10'sd127;
    localparam logic signed [9:0] SMIN = -10'sd128;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic signed [7:0] sum_q, sum_d;
    logic signed [3:0] max_q, max_d;
    logic signed [3:0] min_q, min_d;
    logic              ovf_q, ovf_d;

    logic              xfer;
    logic signed [3:0] a1, a2, a3, tri_max, tri_min;
    logic signed [9:0] step, acc_new;
    logic signed [7:0] sum_sat;
    logic              ovf_now;

    function automatic logic signed [3:0] smax(input logic signed [3:0] a, input logic signed [3:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [3:0] smin(input logic signed [3:0] a, input logic signed [3:0] b);
        return (a < b) ? a : b;
    endfunction

    assign a1 = ans1;
    assign a2 = ans2;
    assign a3 = ans3;

    assign xfer    = (state_q == ACC) && in_valid;
    assign step    = {{6{ans1[3]}}, ans1} + {{6{ans2[3]}}, ans2} + {{6{ans3[3]}}, ans3};
    assign acc_new = {{2{sum_q[7]}}, sum_q} + step;
    assign tri_max = smax(smax(a1, a2), a3);
    assign tri_min = smin(smin(a1, a2), a3);

    always_comb begin
        sum_sat = acc_new[7:0];
        ovf_now = 1'b0;
        if (acc_new > SMAX) begin
            sum_sat = 8'sd127;
            ovf_now = 1'b1;
        end else if (acc_new < SMIN) begin
            sum_sat = -8'sd128;
            ovf_now = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (xfer && cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state; max/min keep last frame's values until the first transfer reloads them
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        max_d = max_q;
        min_d = min_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            cnt_d = 4'd0;
            sum_d = 8'sd0;
            ovf_d = 1'b0;
        end else if (xfer) begin
            cnt_d = cnt_q + 4'd1;
            sum_d = sum_sat;
            ovf_d = ovf_q | ovf_now;
            if (cnt_q == 4'd0) begin
                max_d = tri_max;
                min_d = tri_min;
            end else begin
                max_d = smax(max_q, tri_max);
                min_d = smin(min_q, tri_min);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
            sum_q <= 8'sd0;
            max_q <= 4'sd0;
            min_q <= 4'sd0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            max_q <= max_d;
            min_q <= min_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum     = sum_q;
    assign max_val = max_q;
    assign min_val = min_q;
    assign ovf     = ovf_q;

endmodule
